// File: rtl/gp_dcmp_arbiter_if.sv
// Bus bundle between the four comparator requesters and gp_dcmp_arbiter.
// The slave modport is the arbiter side. The master modport is the user-logic and comparator side.
interface gp_dcmp_arbiter_if;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic       CMP_GT;
  logic       CMP_EQ;
  logic       RESULT_VALID;
  logic [1:0] RESULT_ID;
  logic       RESULT_GT;
  logic       RESULT_EQ;

  modport master (
    output REQ, CMP_GT, CMP_EQ,
    input  GNT, SEL, RESULT_VALID, RESULT_ID, RESULT_GT, RESULT_EQ
  );

  modport slave (
    input  REQ, CMP_GT, CMP_EQ,
    output GNT, SEL, RESULT_VALID, RESULT_ID, RESULT_GT, RESULT_EQ
  );
endinterface

// File: rtl/gp_dcmp_arbiter.sv
// Shares one GreenPAK DCMPMUX/compare block among 4 requesters. It grants, settles, samples GT/EQ and tags the result.
// GP_DCMP_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins). When it is undefined, arbitration is round robin.
module gp_dcmp_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  REQ_MASK      = 4'hF
) (
  input  logic              CLK,
  input  logic              RST,
  gp_dcmp_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The settle window must fit in the counter and cover at least one clock.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $fatal(1, "ERROR: gp_dcmp_arbiter SETTLE_CYCLES=%0d out of range 1..15", SETTLE_CYCLES);
  end

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               res_valid_q, res_valid_d;
  logic [IDX_W-1:0]   res_id_q, res_id_d;
  logic               res_gt_q, res_gt_d;
  logic               res_eq_q, res_eq_d;
  logic [N_REQ-1:0]   req_masked;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   rr_ptr;

  // First set bit of req, searching upward from base with 3->0 wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] base);
    logic [IDX_W-1:0] idx;
    rr_pick = base;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = base + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

`ifdef GP_DCMP_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rr_ptr <= '0;
    else     rr_ptr <= rr_ptr_d;
  end
`endif

  assign req_masked = bus.REQ & REQ_MASK;
  assign winner     = rr_pick(req_masked, rr_ptr);

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_gt_q    <= 1'b0;
      res_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_gt_q    <= res_gt_d;
      res_eq_q    <= res_eq_d;
    end
  end

  // Next state. DONE arbitrates like IDLE, so back-to-back grants have no gap.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_gt_d    = res_gt_q;
    res_eq_d    = res_eq_q;
`ifndef GP_DCMP_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (|req_masked) begin
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          sel_d         = winner;
          cnt_d         = CNT_W'(SETTLE_CYCLES - 1);
          state_d       = SETTLE;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end

      SETTLE: begin
        if (!bus.REQ[sel_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          res_valid_d = 1'b1;
          res_id_d    = sel_q;
          res_gt_d    = bus.CMP_GT;
          res_eq_d    = bus.CMP_EQ;
          gnt_d       = '0;
          state_d     = DONE;
`ifndef GP_DCMP_ARB_FIXED_PRIO_EN
          rr_ptr_d    = sel_q + IDX_W'(1);
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.GNT          = gnt_q;
  assign bus.SEL          = sel_q;
  assign bus.RESULT_VALID = res_valid_q;
  assign bus.RESULT_ID    = res_id_q;
  assign bus.RESULT_GT    = res_gt_q;
  assign bus.RESULT_EQ    = res_eq_q;

endmodule

// File: tb/tb_gp_dcmp_arbiter.sv
// Testbench for gp_dcmp_arbiter. It checks directed scenarios and random traffic against a transaction-level reference model.
module tb_gp_dcmp_arbiter;

  localparam int unsigned SETTLE_A = 2;
  localparam int unsigned SETTLE_M = 3;
  localparam logic [3:0]  MASK_A   = 4'hF;
  localparam logic [3:0]  MASK_M   = 4'b1101;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  gp_dcmp_arbiter_if ifa ();
  gp_dcmp_arbiter_if ifm ();

  gp_dcmp_arbiter #(.SETTLE_CYCLES(SETTLE_A), .REQ_MASK(MASK_A)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa));
  gp_dcmp_arbiter #(.SETTLE_CYCLES(SETTLE_M), .REQ_MASK(MASK_M)) dut_m (.CLK(CLK), .RST(RST), .bus(ifm));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model for dut_a. It tracks the owner of the comparator and how many clocks the grant has lasted.
  int         m_owner;
  int         m_age;
  int         m_rr;
  logic [1:0] m_sel;
  logic       m_rv;
  logic [1:0] m_id;
  logic       m_gt;
  logic       m_eq;

  function automatic int model_pick(logic [3:0] req, int base);
    for (int k = 0; k < 4; k++)
      if (req[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_age = 0; m_rr = 0;
    m_sel = 2'd0; m_rv = 1'b0; m_id = 2'd0; m_gt = 1'b0; m_eq = 1'b0;
  endfunction

  function automatic void model_edge(logic [3:0] req, logic gt, logic eq);
    int w;
    m_rv = 1'b0;
    if (m_owner < 0) begin
`ifdef GP_DCMP_ARB_FIXED_PRIO_EN
      w = model_pick(req & MASK_A, 0);
`else
      w = model_pick(req & MASK_A, m_rr);
`endif
      if (w >= 0) begin
        m_owner = w; m_age = 0; m_sel = 2'(w);
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else begin
      m_age++;
      if (m_age == int'(SETTLE_A)) begin
        m_rv = 1'b1; m_id = 2'(m_owner); m_gt = gt; m_eq = eq;
        m_rr = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  endfunction

  function automatic logic [10:0] model_out();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    return {g, m_sel, m_rv, m_id, m_gt, m_eq};
  endfunction

  function automatic logic [10:0] dut_a_out();
    return {ifa.GNT, ifa.SEL, ifa.RESULT_VALID, ifa.RESULT_ID, ifa.RESULT_GT, ifa.RESULT_EQ};
  endfunction

  function automatic logic [10:0] dut_m_out();
    return {ifm.GNT, ifm.SEL, ifm.RESULT_VALID, ifm.RESULT_ID, ifm.RESULT_GT, ifm.RESULT_EQ};
  endfunction

  // One clock: the model samples the same inputs the DUT sees at the posedge. Outputs are read at the negedge.
  task automatic step();
    @(posedge CLK);
    model_edge(ifa.REQ, ifa.CMP_GT, ifa.CMP_EQ);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ifa.REQ = 4'b0; ifa.CMP_GT = 1'b0; ifa.CMP_EQ = 1'b0;
    ifm.REQ = 4'b0; ifm.CMP_GT = 1'b0; ifm.CMP_EQ = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_a_out() !== 11'b0) $display("FAIL reset_a: got %b expected %b", dut_a_out(), 11'b0);
    else n_pass++;
    n_checks++;
    if (dut_m_out() !== 11'b0) $display("FAIL reset_m: got %b expected %b", dut_m_out(), 11'b0);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    ifa.REQ = 4'b0100; ifa.CMP_GT = 1'b1; ifa.CMP_EQ = 1'b0;
    step();
    n_checks++;
    if ({ifa.GNT, ifa.SEL, ifa.RESULT_VALID} !== {4'b0100, 2'd2, 1'b0})
      $display("FAIL single_grant: got %b expected %b", {ifa.GNT, ifa.SEL, ifa.RESULT_VALID}, {4'b0100, 2'd2, 1'b0});
    else n_pass++;
    step();
    n_checks++;
    if ({ifa.GNT, ifa.RESULT_VALID} !== {4'b0100, 1'b0})
      $display("FAIL single_settle: got %b expected %b", {ifa.GNT, ifa.RESULT_VALID}, {4'b0100, 1'b0});
    else n_pass++;
    step();
    n_checks++;
    if ({ifa.RESULT_VALID, ifa.RESULT_ID, ifa.RESULT_GT, ifa.RESULT_EQ, ifa.GNT} !== {1'b1, 2'd2, 1'b1, 1'b0, 4'b0000})
      $display("FAIL single_result: got %b expected %b",
               {ifa.RESULT_VALID, ifa.RESULT_ID, ifa.RESULT_GT, ifa.RESULT_EQ, ifa.GNT}, {1'b1, 2'd2, 1'b1, 1'b0, 4'b0000});
    else n_pass++;
    ifa.REQ = 4'b0000;
    step();
    n_checks++;
    if ({ifa.RESULT_VALID, ifa.GNT, ifa.SEL, ifa.RESULT_ID, ifa.RESULT_GT} !== {1'b0, 4'b0000, 2'd2, 2'd2, 1'b1})
      $display("FAIL single_hold: got %b expected %b",
               {ifa.RESULT_VALID, ifa.GNT, ifa.SEL, ifa.RESULT_ID, ifa.RESULT_GT}, {1'b0, 4'b0000, 2'd2, 2'd2, 1'b1});
    else n_pass++;
    n_checks++;
    if (dut_a_out() !== model_out()) $display("FAIL single_model: got %b expected %b", dut_a_out(), model_out());
    else n_pass++;
  endtask

  task automatic test_contention();
    int order_exp [5];
    int got;
    int budget;
    logic prev_rv;
`ifdef GP_DCMP_ARB_FIXED_PRIO_EN
    order_exp = '{0, 0, 0, 0, 0};
`else
    order_exp = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    ifa.REQ = 4'b1111;
    step();
    n_checks++;
    if (ifa.GNT !== 4'(1 << order_exp[0])) $display("FAIL contention_first: got %b expected %b", ifa.GNT, 4'(1 << order_exp[0]));
    else n_pass++;
    got = 1; budget = 60; prev_rv = 1'b0;
    while (got < 5 && budget > 0) begin
      ifa.CMP_GT = 1'($urandom_range(0, 1)); ifa.CMP_EQ = 1'($urandom_range(0, 1));
      step();
      budget--;
      n_checks++;
      if (dut_a_out() !== model_out()) $display("FAIL contention_model: got %b expected %b", dut_a_out(), model_out());
      else n_pass++;
      if (prev_rv) begin
        n_checks++;
        if (ifa.GNT !== 4'(1 << order_exp[got]))
          $display("FAIL contention_no_gap: grant %0d got %b expected %b", got, ifa.GNT, 4'(1 << order_exp[got]));
        else n_pass++;
        got++;
      end
      prev_rv = ifa.RESULT_VALID;
    end
    if (got < 5) begin
      n_checks++;
      $display("FAIL contention_timeout: got %0d grants expected 5", got);
    end
    ifa.REQ = 4'b0000;
  endtask

  task automatic test_abort();
    do_reset();
    ifa.REQ = 4'b1000;
    step();
    n_checks++;
    if ({ifa.GNT, ifa.SEL} !== {4'b1000, 2'd3}) $display("FAIL abort_grant3: got %b expected %b", {ifa.GNT, ifa.SEL}, {4'b1000, 2'd3});
    else n_pass++;
    ifa.REQ = 4'b0010;
    step();
    n_checks++;
    if ({ifa.GNT, ifa.RESULT_VALID} !== 5'b0) $display("FAIL abort_drop: got %b expected %b", {ifa.GNT, ifa.RESULT_VALID}, 5'b0);
    else n_pass++;
    step();
    n_checks++;
    if ({ifa.GNT, ifa.SEL, ifa.RESULT_VALID} !== {4'b0010, 2'd1, 1'b0})
      $display("FAIL abort_next: got %b expected %b", {ifa.GNT, ifa.SEL, ifa.RESULT_VALID}, {4'b0010, 2'd1, 1'b0});
    else n_pass++;
    step();
    step();
    n_checks++;
    if ({ifa.RESULT_VALID, ifa.RESULT_ID} !== {1'b1, 2'd1})
      $display("FAIL abort_result: got %b expected %b", {ifa.RESULT_VALID, ifa.RESULT_ID}, {1'b1, 2'd1});
    else n_pass++;
    n_checks++;
    if (dut_a_out() !== model_out()) $display("FAIL abort_model: got %b expected %b", dut_a_out(), model_out());
    else n_pass++;
    ifa.REQ = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    ifa.REQ = 4'b1000; ifa.CMP_GT = 1'b1; ifa.CMP_EQ = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({ifa.RESULT_VALID, ifa.RESULT_ID, ifa.RESULT_GT, ifa.RESULT_EQ} !== {1'b1, 2'd3, 1'b1, 1'b1})
      $display("FAIL areset_pre: got %b expected %b",
               {ifa.RESULT_VALID, ifa.RESULT_ID, ifa.RESULT_GT, ifa.RESULT_EQ}, {1'b1, 2'd3, 1'b1, 1'b1});
    else n_pass++;
    step();
    n_checks++;
    if ({ifa.GNT, ifa.SEL} !== {4'b1000, 2'd3}) $display("FAIL areset_regrant: got %b expected %b", {ifa.GNT, ifa.SEL}, {4'b1000, 2'd3});
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if (dut_a_out() !== 11'b0) $display("FAIL areset_clear: got %b expected %b", dut_a_out(), 11'b0);
    else n_pass++;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    ifa.REQ = 4'b0001; ifa.CMP_GT = 1'b0; ifa.CMP_EQ = 1'b1;
    step();
    n_checks++;
    if ({ifa.GNT, ifa.SEL} !== {4'b0001, 2'd0}) $display("FAIL areset_after: got %b expected %b", {ifa.GNT, ifa.SEL}, {4'b0001, 2'd0});
    else n_pass++;
    step();
    step();
    n_checks++;
    if ({ifa.RESULT_VALID, ifa.RESULT_ID, ifa.RESULT_GT, ifa.RESULT_EQ} !== {1'b1, 2'd0, 1'b0, 1'b1})
      $display("FAIL areset_result: got %b expected %b",
               {ifa.RESULT_VALID, ifa.RESULT_ID, ifa.RESULT_GT, ifa.RESULT_EQ}, {1'b1, 2'd0, 1'b0, 1'b1});
    else n_pass++;
    ifa.REQ = 4'b0000;
  endtask

  task automatic test_mask();
    int ids_exp [4];
    int got;
    int budget;
    int bad;
`ifdef GP_DCMP_ARB_FIXED_PRIO_EN
    ids_exp = '{0, 0, 0, 0};
`else
    ids_exp = '{0, 2, 3, 0};
`endif
    do_reset();
    ifm.REQ = 4'b0010;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if ({ifm.GNT, ifm.RESULT_VALID} !== 5'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL mask_ignored: got %0d active cycles expected 0", bad);
    else n_pass++;
    // A pulse that starts and ends between two posedges is never sampled.
    #1 ifa.REQ = 4'b0100;
    #2 ifa.REQ = 4'b0000;
    step();
    step();
    n_checks++;
    if ({ifa.GNT, ifa.RESULT_VALID} !== 5'b0) $display("FAIL short_pulse: got %b expected %b", {ifa.GNT, ifa.RESULT_VALID}, 5'b0);
    else n_pass++;
    ifm.REQ = 4'b1111;
    got = 0; budget = 60; bad = 0;
    while (got < 4 && budget > 0) begin
      ifm.CMP_GT = 1'($urandom_range(0, 1)); ifm.CMP_EQ = 1'($urandom_range(0, 1));
      step();
      budget--;
      if (ifm.GNT[1] !== 1'b0) bad++;
      if (ifm.RESULT_VALID === 1'b1) begin
        n_checks++;
        if (int'(ifm.RESULT_ID) != ids_exp[got])
          $display("FAIL mask_order: result %0d got id %0d expected %0d", got, ifm.RESULT_ID, ids_exp[got]);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got < 4 || bad != 0) $display("FAIL mask_rr: got %0d results and %0d masked grants expected 4 and 0", got, bad);
    else n_pass++;
    ifm.REQ = 4'b0000;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (ifa.REQ[b]) begin
          if ($urandom_range(0, 15) == 0) ifa.REQ[b] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          ifa.REQ[b] = 1'b1;
        end
      end
      ifa.CMP_GT = 1'($urandom_range(0, 1));
      ifa.CMP_EQ = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if (dut_a_out() !== model_out()) begin
        errs++;
        if (errs <= 10) $display("FAIL random_model: cycle %0d got %b expected %b", c, dut_a_out(), model_out());
      end else n_pass++;
    end
    ifa.REQ = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_abort();
    test_async_reset();
    test_mask();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
